// File: rtl/frame_transmit_if.sv
// Request/payload and byte-stream handshake signals shared between the
// frame requester/UART side (master) and the frame transmitter (slave).
interface frame_transmit_if;
  logic        send;
  logic [7:0]  func;
  logic [31:0] word_a;
  logic [31:0] word_b;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;

  modport master (
    output send, func, word_a, word_b, tx_ready,
    input  tx_data, tx_valid, busy, done
  );

  modport slave (
    input  send, func, word_a, word_b, tx_ready,
    output tx_data, tx_valid, busy, done
  );
endinterface

// File: rtl/frame_transmit.sv
// Serialises an 11-byte frame (header, function code, two 32-bit words,
// additive checksum) onto a valid/ready byte stream for a UART transmitter.
module frame_transmit #(
  parameter logic [7:0] HEADER    = 8'h55,
  parameter int         FRAME_LEN = 11
) (
  input  logic             clock,
  input  logic             rst_n,
  frame_transmit_if.slave  link
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  csum_q, csum_d;
  logic [7:0]  func_q, func_d;
  logic [31:0] word_a_q, word_a_d;
  logic [31:0] word_b_q, word_b_d;
  logic        armed_q;
  logic [7:0]  frame_bytes [0:10];
  logic [7:0]  cur_byte;
  logic        xfer;

  assign frame_bytes[0]  = HEADER;
  assign frame_bytes[1]  = func_q;
  assign frame_bytes[10] = csum_q;

  for (genvar gi = 0; gi < 4; gi++) begin : g_payload
    assign frame_bytes[2 + gi] = word_a_q[31 - 8*gi -: 8];
    assign frame_bytes[6 + gi] = word_b_q[31 - 8*gi -: 8];
  end

  always_comb begin
    cur_byte = 8'h00;
    if (idx_q <= LAST_IDX) cur_byte = frame_bytes[idx_q];
  end

  assign xfer          = (state_q == S_SEND) && link.tx_ready;
  assign link.tx_valid = (state_q == S_SEND);
  assign link.busy     = (state_q != S_IDLE);
  assign link.done     = (state_q == S_DONE);
  assign link.tx_data  = (state_q == S_SEND) ? cur_byte : 8'h00;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    csum_d   = csum_q;
    func_d   = func_q;
    word_a_d = word_a_q;
    word_b_d = word_b_q;
    case (state_q)
      S_IDLE: begin
        if (link.send && armed_q) begin
          state_d  = S_SEND;
          idx_d    = 4'd0;
          csum_d   = 8'h00;
          func_d   = link.func;
          word_a_d = link.word_a;
          word_b_d = link.word_b;
        end
      end
      S_SEND: begin
        if (xfer) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + 4'd1;
            // Header (index 0) is excluded from the check byte.
            if (idx_q != 4'd0) csum_d = csum_q + cur_byte;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= 4'd0;
      csum_q   <= 8'h00;
      func_q   <= 8'h00;
      word_a_q <= 32'h0;
      word_b_q <= 32'h0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      csum_q   <= csum_d;
      func_q   <= func_d;
      word_a_q <= word_a_d;
      word_b_q <= word_b_d;
      // The first edge after reset release only arms the block, so a send
      // coincident with that edge is dropped.
      armed_q  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_frame_transmit.sv
// Directed and randomized checks of frame_transmit against a byte-list model.
module tb_frame_transmit;
  typedef logic [7:0] byte_q_t [$];

  logic clock;
  logic rst_n;
  int   total_cnt = 0;
  int   pass_cnt  = 0;

  frame_transmit_if bus ();

  frame_transmit #(.HEADER(8'h55), .FRAME_LEN(11)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .link  (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic byte_q_t model(input logic [7:0] f, input logic [31:0] a, input logic [31:0] b);
    byte_q_t q;
    int sum;
    q.push_back(8'h55);
    q.push_back(f);
    for (int k = 3; k >= 0; k--) q.push_back(8'((a >> (8*k)) & 32'hFF));
    for (int k = 3; k >= 0; k--) q.push_back(8'((b >> (8*k)) & 32'hFF));
    sum = 0;
    for (int k = 1; k <= 9; k++) sum += int'(q[k]);
    q.push_back(8'(sum % 256));
    return q;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // mode: 0 ready high, 1 random ready, 2 random + 5-cycle stall on byte 4,
  //       3 send pulses during byte 3 and DONE, 4 reset after byte 5, 5 word_b swap
  task automatic run_frame(input logic [7:0] f, input logic [31:0] a, input logic [31:0] b,
                           input int mode, input string tag, output logic [7:0] chk);
    byte_q_t exp_q;
    byte_q_t got_q;
    int      cyc;
    int      stall;
    bit      pulsed;
    bit      seen_done;
    logic    rdy;
    int      n;
    exp_q = model(f, a, b);
    chk = 8'hxx;
    bus.send = 1'b1; bus.func = f; bus.word_a = a; bus.word_b = b;
    @(negedge clock);
    bus.send = 1'b0;
    if (mode == 5) bus.word_b = 32'h12345678;
    else begin bus.func = 8'($urandom); bus.word_a = $urandom; bus.word_b = $urandom; end
    check({tag, "_busy_start"}, bus.busy, 1'b1);
    cyc = 0; stall = 0; pulsed = 0; seen_done = 0; rdy = 1'b0;
    while (cyc < 200) begin
      cyc++;
      if (bus.done) begin seen_done = 1; break; end
      if (mode == 4 && got_q.size() == 6) begin
        rst_n = 1'b0;
        #1;
        check({tag, "_abort_valid"}, bus.tx_valid, 1'b0);
        check({tag, "_abort_busy"}, bus.busy, 1'b0);
        check({tag, "_abort_data"}, bus.tx_data, 8'h00);
        for (int k = 0; k < 6; k++) check($sformatf("%s_byte%0d", tag, k), got_q[k], exp_q[k]);
        return;
      end
      n = got_q.size();
      if (!rdy && cyc > 1 && n < 11)
        check($sformatf("%s_hold%0d", tag, n), bus.tx_data, exp_q[n]);
      if (mode == 0 || mode == 4 || mode == 5) rdy = 1'b1;
      else if (mode == 2 && n == 4 && stall < 5) begin rdy = 1'b0; stall++; end
      else rdy = 1'($urandom & 1);
      if (mode == 3 && n == 3 && !pulsed) begin
        bus.send = 1'b1; bus.word_a = ~a; pulsed = 1;
      end else bus.send = 1'b0;
      bus.tx_ready = rdy;
      if (rdy && bus.tx_valid) got_q.push_back(bus.tx_data);
      @(negedge clock);
    end
    check({tag, "_done_seen"}, seen_done, 1'b1);
    if (mode == 0 || mode == 5) check({tag, "_latency"}, cyc, 12);
    check({tag, "_done_valid"}, bus.tx_valid, 1'b0);
    check({tag, "_done_busy"}, bus.busy, 1'b1);
    check({tag, "_xfer_count"}, got_q.size(), 11);
    for (int k = 0; k < 11 && k < got_q.size(); k++)
      check($sformatf("%s_byte%0d", tag, k), got_q[k], exp_q[k]);
    if (got_q.size() == 11) chk = got_q[10];
    bus.tx_ready = 1'b0;
    if (mode == 3) begin bus.send = 1'b1; bus.word_a = ~a; end
    @(negedge clock);
    bus.send = 1'b0;
    check({tag, "_idle_busy"}, bus.busy, 1'b0);
    check({tag, "_idle_done"}, bus.done, 1'b0);
    $display("frame %s func=%02h a=%08h b=%08h transfers=%0d cycles=%0d", tag, f, a, b, got_q.size(), cyc);
  endtask

  initial begin
    logic [7:0] chk;
    bus.send = 1'b0; bus.func = 8'h00; bus.word_a = 32'h0; bus.word_b = 32'h0;
    bus.tx_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_valid", bus.tx_valid, 1'b0);
    check("rst_busy",  bus.busy, 1'b0);
    check("rst_done",  bus.done, 1'b0);
    check("rst_data",  bus.tx_data, 8'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge clock);

    run_frame(8'h11, 32'h00000064, 32'h000003E8, 0, "basic", chk);
    check("basic_check_byte", chk, 8'h60);
    run_frame(8'h12, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, "wrap", chk);
    check("wrap_check_byte", chk, 8'h0A);
    run_frame(8'h11, 32'h00000064, 32'h000003E8, 2, "backpressure", chk);
    run_frame(8'h11, 32'h00000064, 32'h000003E8, 3, "busy_reject", chk);
    run_frame(8'h12, 32'hCAFEBABE, 32'h00000001, 0, "after_busy", chk);
    run_frame(8'h11, 32'h00000064, 32'h000003E8, 4, "abort", chk);

    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("abort_no_done", bus.done, 1'b0);
    end
    bus.send = 1'b1; bus.func = 8'h12; bus.word_a = 32'h1; bus.word_b = 32'h2;
    @(posedge clock);
    rst_n = 1'b1;
    @(negedge clock);
    bus.send = 1'b0;
    check("release_send_ignored", bus.busy, 1'b0);
    @(negedge clock);
    run_frame(8'h11, 32'h00000064, 32'h000003E8, 0, "post_reset", chk);
    run_frame(8'h11, 32'h00000064, 32'h000003E8, 5, "input_hold", chk);
    check("input_hold_check_byte", chk, 8'h60);

    for (int i = 0; i < 5; i++)
      run_frame(8'($urandom), $urandom, $urandom, 1, $sformatf("rand%0d", i), chk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/frame_transmit.md
FRAME_TRANSMIT -- requirements
Module: frame_transmit

Interface
REQ-001 Parameter HEADER, default 8'h55, is the frame header byte.
REQ-002 Parameter FRAME_LEN, default 11, is the total bytes per frame; it is fixed at 11 and other values are unsupported.
REQ-003 Port clock, input, 1, is the single clock; all logic is rising-edge.
REQ-004 Port rst_n, input, 1, is the asynchronous active-low reset.
REQ-005 Port send, input, 1, is a one-cycle frame request, sampled only in IDLE.
REQ-006 Port func, input, 8, is the function code, sent as byte 1 (0x11 = single pulse, 0x12 = double pulse; not checked).
REQ-007 Port word_a, input, 32, is the first payload word, sent as bytes 2..5, MSB first.
REQ-008 Port word_b, input, 32, is the second payload word, sent as bytes 6..9, MSB first.
REQ-009 Port tx_data, output, 8, is the byte offered to the UART transmitter.
REQ-010 Port tx_valid, output, 1, means tx_data is valid.
REQ-011 Port tx_ready, input, 1, means the UART accepts a byte; a transfer occurs on any edge with tx_valid and tx_ready both high.
REQ-012 Port busy, output, 1, is high from request acceptance through the DONE cycle.
REQ-013 Port done, output, 1, is a one-cycle pulse after the final byte transfers.

Function
REQ-014 Frame order shall be: byte0 HEADER, byte1 func, bytes2-5 word_a[31:24..7:0], bytes6-9 word_b[31:24..7:0], byte10 check.
REQ-015 The check byte shall be the 8-bit sum, modulo 256, of bytes 1..9, with the header excluded and carries discarded.
REQ-016 The FSM shall have exactly three states: IDLE, SEND, DONE.
REQ-017 IDLE with send=1 shall register func, word_a and word_b on that edge, clear the byte index and checksum, and move to SEND; busy and tx_valid go high the next cycle.
REQ-018 In IDLE, tx_valid=0, busy=0 and done=0.
REQ-019 In SEND, tx_valid shall be 1 continuously, and tx_data shall be the byte selected by the 4-bit index (0..10) from the registered copies only.
REQ-020 tx_data shall be held stable while tx_valid=1 and tx_ready=0, for any number of stall cycles.
REQ-021 Each transfer shall increment the index by 1 and add the transferred byte into the checksum accumulator when its index is 1..9.
REQ-022 At most one byte shall transfer per cycle.
REQ-023 When byte 10 transfers, the FSM shall move to DONE with tx_valid=0 from the next cycle; the index shall not wrap past 10.
REQ-024 DONE shall last exactly one cycle with done=1 and busy=1, then return to IDLE.
REQ-025 send outside IDLE (SEND or DONE) shall be ignored and not queued, and shall leave the registered payload unchanged.
REQ-026 Input changes on func, word_a or word_b after acceptance shall not affect the frame in flight.
REQ-027 With tx_ready held high, a frame shall take 11 consecutive transfer cycles; done rises 12 cycles after the request edge.
REQ-028 The minimum request-to-request spacing shall be 13 cycles: the earliest accepted send is the cycle after DONE.

Reset
REQ-029 rst_n low shall asynchronously force state IDLE, index 0, checksum 0, tx_data 8'h00, tx_valid 0, busy 0, done 0, and all registered payload 0.
REQ-030 Reset asserted mid-frame shall abort the frame immediately, with no done pulse and no remaining bytes.
REQ-031 After reset deasserts, the block shall accept a new send normally.
REQ-032 send coincident with the reset release edge shall be ignored.

Verification
REQ-033 Basic frame: func=0x11, word_a=0x00000064, word_b=0x000003E8, tx_ready=1 -> bytes 55 11 00 00 00 64 00 00 03 E8 60 on 11 consecutive cycles, then done for 1 cycle.
REQ-034 Checksum wrap: func=0x12, word_a=0xFFFFFFFF, word_b=0xFFFFFFFF -> check byte = (0x12 + 8*0xFF) mod 256 = 0x0A.
REQ-035 Back-pressure: tx_ready toggles randomly and is held 0 for 5 cycles on byte 4 -> tx_data is stable 0x00 throughout, the sequence is identical to REQ-033, and exactly 11 transfers occur.
REQ-036 Busy rejection: send is pulsed during byte 3 and during DONE with different word_a -> only the original frame is sent, and the second frame starts only for a send after busy=0.
REQ-037 Reset mid-frame: rst_n=0 after byte 5 transfers -> tx_valid=0 immediately and done never pulses; a fresh send yields a complete correct frame starting with 0x55.
REQ-038 Input hold: word_b changes from 0x000003E8 to 0x12345678 one cycle after acceptance -> the frame still carries 00 00 03 E8 and check 0x60.
